// File: rtl/seg_display_pkg.sv
// Shared constants, FSM state type and sizing helper for the multiplexed 7-segment driver.
package seg_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  // Number of BCD nibbles needed to hold any DATA_W-bit binary value
  function automatic int unsigned bcd_digits(input int unsigned data_w);
    return (data_w + 2) / 3;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit to active-low 7-segment lookup.
module seg_hex_decode
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    unique case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Multi-digit 7-segment driver: hex or double-dabble decimal load, time-multiplexed scan.
// Optional leading-zero blanking enabled by defining SEG_LZB_EN.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CLK_DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value_i,
  input  logic                  mode_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  ovf_o,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_n_o
);

  localparam int unsigned BCD_N     = bcd_digits(DATA_W);
  localparam int unsigned BCD_W     = 4 * BCD_N;
  localparam int unsigned DIG_W     = 4 * NUM_DIGITS;
  localparam int unsigned HEX_EXT_W = (DATA_W > DIG_W) ? DATA_W : DIG_W;
  localparam int unsigned BCD_EXT_W = (BCD_W > DIG_W) ? BCD_W : DIG_W;
  localparam int unsigned SCAN_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_W     = $clog2(CLK_DIV);
  localparam int unsigned ITER_W    = $clog2(DATA_W);

  state_t                       state;
  logic [DATA_W-1:0]            shift_q;
  logic [BCD_W-1:0]             bcd_q;
  logic [BCD_W-1:0]             bcd_adj;
  logic [ITER_W-1:0]            iter_q;
  logic [NUM_DIGITS-1:0][3:0]   digits_q;
  logic                         ovf_q;
  logic                         ready_q;
  logic [DIV_W-1:0]             presc_q;
  logic [SCAN_W-1:0]            scan_q;
  logic [6:0]                   seg_q;
  logic [NUM_DIGITS-1:0]        an_q;
  logic [HEX_EXT_W-1:0]         hex_ext;
  logic [BCD_EXT_W-1:0]         bcd_ext;
  logic [3:0]                   cur_nibble;
  logic [6:0]                   dec_seg;
  logic [6:0]                   seg_next;
  logic                         accept;

  assign accept  = valid_i && ready_q;
  assign hex_ext = HEX_EXT_W'(value_i);
  assign bcd_ext = BCD_EXT_W'(bcd_q);

  // Double-dabble correction step: +3 on every BCD nibble >= 5 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BCD_N); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Load / conversion FSM; the digit register only changes on hex accept or COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (!mode_i) begin
              digits_q <= hex_ext[DIG_W-1:0];
              ovf_q    <= |(hex_ext >> DIG_W);
            end else begin
              shift_q <= value_i;
              bcd_q   <= '0;
              iter_q  <= '0;
              ready_q <= 1'b0;
              state   <= CONV;
            end
          end
        end
        CONV: begin
          bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
          shift_q <= shift_q << 1;
          iter_q  <= iter_q + ITER_W'(1);
          if (iter_q == ITER_W'(DATA_W - 1)) state <= COMMIT;
        end
        COMMIT: begin
          digits_q <= bcd_ext[DIG_W-1:0];
          ovf_q    <= |(bcd_ext >> DIG_W);
          ready_q  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur_nibble = digits_q[scan_q];

  seg_hex_decode u_dec (
    .nibble (cur_nibble),
    .seg_c  (dec_seg)
  );

`ifdef SEG_LZB_EN
  // lead_zero[i]: digit i and every digit above it are zero
  logic [NUM_DIGITS-1:0] lead_zero;
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (digits_q[NUM_DIGITS-1] == 4'd0);
    for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (digits_q[i] == 4'd0);
    end
  end
`endif

  always_comb begin
    seg_next = dec_seg;
`ifdef SEG_LZB_EN
    if ((scan_q != '0) && lead_zero[scan_q]) seg_next = SEG_BLANK;
`endif
    if (ovf_q) seg_next = SEG_DASH;
  end

  // Refresh prescaler, scan index and registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      if (presc_q == DIV_W'(CLK_DIV - 1)) begin
        presc_q <= '0;
        scan_q  <= (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
      end else begin
        presc_q <= presc_q + DIV_W'(1);
      end
      an_q  <= ~(NUM_DIGITS'(1) << scan_q);
      seg_q <= seg_next;
    end
  end

  assign ready_o = ready_q;
  assign ovf_o   = ovf_q;
  assign seg_o   = seg_q;
  assign an_n_o  = an_q;

endmodule
